// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared definitions for the register-file port arbiter.
//   - RF_ADDR_W / RF_DATA_W : default register address / data widths
//   - REG_ZERO / REG_SP / REG_GP : architectural register numbers x0, x2, x3
//   - rd_state_e : debug-read sequencer states
package rf_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 2;
  localparam int REG_GP   = 3;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_DRAIN  = 2'd1,
    RD_SAMPLE = 2'd2,
    RD_DONE   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/rf_dbg_wfifo.sv
// rf_dbg_wfifo: small synchronous FIFO holding queued debug register writes.
// Ports:
//   clk, rstn        : clock (posedge), asynchronous active-low reset
//   push, push_data  : enqueue request; ignored while full
//   pop              : dequeue request; ignored while empty
//   full, empty      : occupancy flags (registered state, no lookahead)
//   head             : oldest entry, valid while !empty
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_dbg_wfifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // Fullness is judged at cycle start: a pop in the same cycle does not
  // make room for a push until the next cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage needs no reset; only entries behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares the RF write port and read port ra2 between core
// writeback and the debug unit.
// Ports:
//   clk, rstn                    : clock, asynchronous active-low reset
//   wb_we/wb_wa/wb_wd            : core writeback (always wins, zero latency)
//   dbg_wr_valid/ready/addr/data : debug write request (queued in a FIFO)
//   dbg_rd_valid/ready/addr      : debug read request
//   dbg_rd_data, dbg_rd_done     : read result and one-cycle completion pulse
//   core_stall                   : asks the core to idle so the FIFO drains
//   rf_we/rf_wa/rf_wd            : RF write port
//   rf_ra2, rf_rd2               : RF third read port
//   dbg_wr_err                   : only with RF_ARB_PROTECT_EN; pulses when a
//                                  debug write to x2/x3 is discarded
// Optional feature macro: RF_ARB_PROTECT_EN (protects x2/x3 from debug writes).
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              dbg_wr_valid,
  output logic              dbg_wr_ready,
  input  logic [ADDR_W-1:0] dbg_wr_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  input  logic              dbg_rd_valid,
  output logic              dbg_rd_ready,
  input  logic [ADDR_W-1:0] dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              dbg_rd_done,
  output logic              core_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd2
`ifdef RF_ARB_PROTECT_EN
  ,
  output logic              dbg_wr_err
`endif
);

`ifdef RF_ARB_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [SW-1:0]     STARVE_ARM = SW'(STARVE_MAX - 1);
  localparam logic [ADDR_W-1:0] A_ZERO     = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] A_SP       = ADDR_W'(REG_SP);
  localparam logic [ADDR_W-1:0] A_GP       = ADDR_W'(REG_GP);

  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic                     wr_accept, wr_protected, slot_busy;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     stall_q, stall_d;
  rd_state_e                state_q, state_d;
  logic [ADDR_W-1:0]        raddr_q, raddr_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;

  // ---------------- debug write queue ----------------
  assign dbg_wr_ready = !fifo_full;
  assign wr_accept    = dbg_wr_valid && !fifo_full;
  assign wr_protected = PROTECT_EN && ((dbg_wr_addr == A_SP) || (dbg_wr_addr == A_GP));
  // x0 and protected writes complete the handshake but are never queued.
  assign fifo_push    = wr_accept && (dbg_wr_addr != A_ZERO) && !wr_protected;

  rf_dbg_wfifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_wfifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data ({dbg_wr_addr, dbg_wr_data}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // ---------------- write slot ----------------
  // A core write to x0 is a no-op, so it leaves the slot free for the queue.
  assign slot_busy = wb_we && (wb_wa != A_ZERO);
  assign fifo_pop  = !slot_busy && !fifo_empty;

  always_comb begin
    rf_we = 1'b0;
    rf_wa = wb_wa;
    rf_wd = wb_wd;
    if (slot_busy) begin
      rf_we = rstn;
    end else if (!fifo_empty) begin
      rf_we          = rstn;
      {rf_wa, rf_wd} = fifo_head;
    end
  end

  // ---------------- starvation / stall ----------------
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop)    starve_d = '0;
    else if (starve_q != STARVE_TOP) starve_d = starve_q + 1'b1;
    // Once raised, the stall holds until the queue actually makes progress.
    stall_d = !fifo_pop && ((!fifo_empty && (starve_q == STARVE_ARM)) || stall_q);
  end

  assign core_stall = stall_q;

  // ---------------- debug read sequencer ----------------
  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q;
    rdata_d      = rdata_q;
    dbg_rd_ready = 1'b0;
    dbg_rd_done  = 1'b0;
    rf_ra2       = '0;
    case (state_q)
      RD_IDLE: begin
        dbg_rd_ready = 1'b1;
        if (dbg_rd_valid) begin
          raddr_d = dbg_rd_addr;
          state_d = fifo_empty ? RD_SAMPLE : RD_DRAIN;
        end
      end
      // Older queued writes must land before the read is coherent.
      RD_DRAIN: begin
        if (fifo_empty) state_d = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        rf_ra2 = raddr_q;
        // Bypass the write landing this very cycle, which the RF read misses.
        if (raddr_q == A_ZERO)                    rdata_d = '0;
        else if (rf_we && (rf_wa == raddr_q))     rdata_d = rf_wd;
        else                                      rdata_d = rf_rd2;
        state_d = RD_DONE;
      end
      RD_DONE: begin
        dbg_rd_done = 1'b1;
        state_d     = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign dbg_rd_data = rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
      state_q  <= RD_IDLE;
      raddr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef RF_ARB_PROTECT_EN
  logic err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= wr_accept && wr_protected;
  end
  assign dbg_wr_err = err_q;
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed bench for rf_port_arbiter with a behavioural
// register file attached to the write port and ra2.
module tb_rf_port_arbiter;

  logic        clk;
  logic        rstn;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        dbg_wr_valid, dbg_wr_ready;
  logic [4:0]  dbg_wr_addr;
  logic [31:0] dbg_wr_data;
  logic        dbg_rd_valid, dbg_rd_ready;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data;
  logic        dbg_rd_done, core_stall;
  logic        rf_we;
  logic [4:0]  rf_wa, rf_ra2;
  logic [31:0] rf_wd, rf_rd2;
`ifdef RF_ARB_PROTECT_EN
  logic        dbg_wr_err;
`endif

  int total = 0;
  int bad   = 0;

  rf_port_arbiter dut (
    .clk          (clk),
    .rstn         (rstn),
    .wb_we        (wb_we),
    .wb_wa        (wb_wa),
    .wb_wd        (wb_wd),
    .dbg_wr_valid (dbg_wr_valid),
    .dbg_wr_ready (dbg_wr_ready),
    .dbg_wr_addr  (dbg_wr_addr),
    .dbg_wr_data  (dbg_wr_data),
    .dbg_rd_valid (dbg_rd_valid),
    .dbg_rd_ready (dbg_rd_ready),
    .dbg_rd_addr  (dbg_rd_addr),
    .dbg_rd_data  (dbg_rd_data),
    .dbg_rd_done  (dbg_rd_done),
    .core_stall   (core_stall),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .rf_ra2       (rf_ra2),
    .rf_rd2       (rf_rd2)
`ifdef RF_ARB_PROTECT_EN
    ,
    .dbg_wr_err   (dbg_wr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: sync write, async read, x0 reads zero.
  logic [31:0] rf_mem [32];
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;
  assign rf_rd2 = (rf_ra2 == 5'd0) ? 32'd0 : rf_mem[rf_ra2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // write-slot passthrough vectors with an empty queue
    vecs[0] = '{1'b1, 5'd5,  32'h0000_A5A5, 1'b1, 5'd5,  32'h0000_A5A5};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFF_0001, 1'b1, 5'd31, 32'hFFFF_0001};
    vecs[2] = '{1'b1, 5'd1,  32'h1234_5678, 1'b1, 5'd1,  32'h1234_5678};
    vecs[3] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b0, 5'd6,  32'h0000_0066, 1'b0, 5'd0,  32'h0};
    vecs[5] = '{1'b1, 5'd16, 32'h8000_0000, 1'b1, 5'd16, 32'h8000_0000};

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;

    rstn = 1'b0;
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hA5A5;
    dbg_wr_valid = 1'b0; dbg_wr_addr = '0; dbg_wr_data = '0;
    dbg_rd_valid = 1'b0; dbg_rd_addr = '0;

    // ---- reset state ----
    #12;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_wr_ready", dbg_wr_ready, 1'b1);
    chk("rst_rd_ready", dbg_rd_ready, 1'b1);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_done", dbg_rd_done, 1'b0);
    chk("rst_rd_data", dbg_rd_data, 32'd0);
    rstn = 1'b1;
    #1;
    chk("pass_rf_we", rf_we, 1'b1);
    chk("pass_rf_wa", rf_wa, 32'd5);
    chk("pass_rf_wd", rf_wd, 32'hA5A5);

    // ---- table-driven write-slot vectors ----
    for (int i = 0; i < 6; i++) begin
      wb_we = vecs[i].we; wb_wa = vecs[i].wa; wb_wd = vecs[i].wd;
      #2;
      chk($sformatf("vec%0d_we", i), rf_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_wa", i), rf_wa, vecs[i].exp_wa);
        chk($sformatf("vec%0d_wd", i), rf_wd, vecs[i].exp_wd);
      end
    end

    // ---- idle-slot drain ----
    tick();
    wb_we = 1'b0;
    dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd7; dbg_wr_data = 32'h1234;
    #1;
    chk("drain_ready", dbg_wr_ready, 1'b1);
    chk("drain_pre_we", rf_we, 1'b0);
    tick();
    dbg_wr_valid = 1'b0;
    #1;
    chk("drain_we", rf_we, 1'b1);
    chk("drain_wa", rf_wa, 32'd7);
    chk("drain_wd", rf_wd, 32'h1234);
    tick();
    chk("drain_empty_we", rf_we, 1'b0);
    chk("drain_rf7", rf_mem[7], 32'h1234);

    // ---- backpressure and starvation stall ----
    wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'h0111;
    dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd10; dbg_wr_data = 32'hA0;
    tick();                                   // E1: first write queued
    dbg_wr_addr = 5'd11; dbg_wr_data = 32'hB0;
    #1;
    chk("bp_ready_1", dbg_wr_ready, 1'b1);
    tick();                                   // E2: second write queued
    chk("bp_ready_full", dbg_wr_ready, 1'b0);
    dbg_wr_valid = 1'b0;
    chk("bp_core_wins", rf_wa, 32'd1);
    tick();                                   // E3
    tick();                                   // E4
    chk("stall_not_yet", core_stall, 1'b0);
    tick();                                   // E5
    chk("stall_rise", core_stall, 1'b1);
    tick();                                   // E6: still starved
    chk("stall_hold", core_stall, 1'b1);
    wb_we = 1'b0;
    #1;
    chk("bp_head_we", rf_we, 1'b1);
    chk("bp_head_wa", rf_wa, 32'd10);
    tick();                                   // first pop
    chk("stall_drop", core_stall, 1'b0);
    chk("bp_second_wa", rf_wa, 32'd11);
    chk("bp_ready_free", dbg_wr_ready, 1'b1);
    tick();
    chk("bp_empty_we", rf_we, 1'b0);
    chk("bp_rf10", rf_mem[10], 32'hA0);
    chk("bp_rf11", rf_mem[11], 32'hB0);

    // ---- read with write bypass ----
    dbg_rd_valid = 1'b1; dbg_rd_addr = 5'd9;
    #1;
    chk("byp_ready", dbg_rd_ready, 1'b1);
    tick();                                   // accept -> SAMPLE
    dbg_rd_valid = 1'b0;
    wb_we = 1'b1; wb_wa = 5'd9; wb_wd = 32'hDEAD;
    #1;
    chk("byp_ra2", rf_ra2, 32'd9);
    chk("byp_busy", dbg_rd_ready, 1'b0);
    chk("byp_done_early", dbg_rd_done, 1'b0);
    tick();
    wb_we = 1'b0;
    chk("byp_done", dbg_rd_done, 1'b1);
    chk("byp_data", dbg_rd_data, 32'hDEAD);
    chk("byp_ra2_idle", rf_ra2, 32'd0);
    tick();
    chk("byp_done_pulse", dbg_rd_done, 1'b0);
    chk("byp_ready_back", dbg_rd_ready, 1'b1);

    // ---- read after queued write (DRAIN path) ----
    dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd4; dbg_wr_data = 32'h55;
    tick();                                   // write queued
    dbg_wr_valid = 1'b0;
    dbg_rd_valid = 1'b1; dbg_rd_addr = 5'd4;
    tick();                                   // read accepted -> DRAIN, pop
    dbg_rd_valid = 1'b0;
    chk("q_drain_ra2", rf_ra2, 32'd0);
    chk("q_drain_done", dbg_rd_done, 1'b0);
    tick();                                   // SAMPLE
    chk("q_sample_ra2", rf_ra2, 32'd4);
    tick();                                   // DONE
    chk("q_done", dbg_rd_done, 1'b1);
    chk("q_data", dbg_rd_data, 32'h55);
    tick();

    // ---- read of x0 ----
    dbg_rd_valid = 1'b1; dbg_rd_addr = 5'd0;
    tick();
    dbg_rd_valid = 1'b0;
    tick();
    chk("x0_done", dbg_rd_done, 1'b1);
    chk("x0_data", dbg_rd_data, 32'd0);
    tick();

    // ---- debug write to x0 is accepted and dropped ----
    dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd0; dbg_wr_data = 32'hFFFF;
    #1;
    chk("wx0_ready", dbg_wr_ready, 1'b1);
    tick();
    dbg_wr_valid = 1'b0;
    #1;
    chk("wx0_no_we", rf_we, 1'b0);

    // ---- debug write to x2 ----
    dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd2; dbg_wr_data = 32'hFFFF;
    tick();
    dbg_wr_valid = 1'b0;
    #1;
`ifdef RF_ARB_PROTECT_EN
    chk("sp_no_we", rf_we, 1'b0);
    chk("sp_err", dbg_wr_err, 1'b1);
    tick();
    chk("sp_err_pulse", dbg_wr_err, 1'b0);
    chk("sp_rf2_kept", rf_mem[2], 32'h1002);
`else
    chk("sp_we", rf_we, 1'b1);
    chk("sp_wa", rf_wa, 32'd2);
    tick();
    chk("sp_rf2", rf_mem[2], 32'hFFFF);
`endif

    // ---- reset mid-read discards the read and the queue ----
    wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'h0222;
    dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd6; dbg_wr_data = 32'h66;
    tick();
    dbg_wr_valid = 1'b0;
    dbg_rd_valid = 1'b1; dbg_rd_addr = 5'd5;
    tick();                                   // read parked in DRAIN
    dbg_rd_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mr_rst_we", rf_we, 1'b0);
    chk("mr_rst_ready", dbg_rd_ready, 1'b1);
    wb_we = 1'b0;
    #1;
    rstn = 1'b1;
    #1;
    chk("mr_queue_gone", rf_we, 1'b0);
    chk("mr_wr_ready", dbg_wr_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mr_no_done%0d", i), dbg_rd_done, 1'b0);
    end
    chk("mr_rf6_untouched", rf_mem[6], 32'h1006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
Shares the register file's single write port and its third read port (ra2) between the core writeback stage and the PDU debug unit. Core writeback always has priority and passes through with zero added latency. Debug writes are buffered in a small FIFO and drained in idle write slots; a starvation counter raises a core stall when the FIFO cannot drain. Debug reads are sequenced by a small FSM on ra2 with write-bypass, so results are coherent.

Parameters:
QDEPTH, 2, debug write FIFO depth (power of 2, ≥2)
STARVE_MAX, 4, cycles a non-empty FIFO may go unserved before core_stall asserts (≥1)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  system clock, posedge
rstn  in  1  asynchronous active-low reset
wb_we  in  1  core writeback enable
wb_wa  in  ADDR_W  core writeback address
wb_wd  in  DATA_W  core writeback data
dbg_wr_valid  in  1  debug write request
dbg_wr_ready  out  1  debug write accepted when valid&ready at posedge
dbg_wr_addr  in  ADDR_W  debug write address
dbg_wr_data  in  DATA_W  debug write data
dbg_rd_valid  in  1  debug read request
dbg_rd_ready  out  1  debug read accepted when valid&ready at posedge
dbg_rd_addr  in  ADDR_W  debug read address
dbg_rd_data  out  DATA_W  registered read result
dbg_rd_done  out  1  one-cycle pulse: dbg_rd_data valid
core_stall  out  1  registered; core holds wb_we=0 while high
rf_we  out  1  to RF we
rf_wa  out  ADDR_W  to RF wa
rf_wd  out  DATA_W  to RF wd
rf_ra2  out  ADDR_W  to RF ra2
rf_rd2  in  DATA_W  from RF rd2

Behaviour:
- Reset (async, rstn=0): FIFO empty, starvation counter 0, FSM IDLE. core_stall=0, dbg_rd_done=0, dbg_rd_data=0, dbg_wr_ready=1, dbg_rd_ready=1. rf_we is forced 0 while rstn=0. A reset mid-read drops that read with no done pulse. Reset discards queued writes.
- Write slot is combinational. A slot is busy if wb_we=1 and wb_wa!=0. If busy, rf_we/wa/wd = wb_*. Else, if the FIFO is non-empty, drive the FIFO head with rf_we=1 and pop at posedge. Otherwise rf_we=0.
- A write to x0 from either side is a no-op and never reaches the RF. A debug write to x0 is still accepted (ready honoured) and discarded at push.
- FIFO: dbg_wr_ready = !full, combinational from occupancy. Push and pop in the same cycle are allowed when full; the push is accepted only if not full at cycle start. Debug writes retire in arrival order. A debug write that follows a core write to the same register overwrites it.
- Starvation counter: increments each cycle the FIFO is non-empty and no pop occurs, saturating at STARVE_MAX. It clears on a pop or when the FIFO is empty. core_stall <= (counter==STARVE_MAX-1 && no pop) || (core_stall && no pop), so it stays high until the first pop. If wb_we=1 arrives during a stall (protocol violation), the core still wins and the stall persists.
- Read FSM states: IDLE, DRAIN, SAMPLE, DONE. dbg_rd_ready=1 only in IDLE. rf_ra2=0 except in SAMPLE, where it equals the latched address.
  - IDLE: on accept, latch the address and go to DRAIN if the FIFO is non-empty, else SAMPLE.
  - DRAIN: wait until the FIFO is empty, then go to SAMPLE.
  - SAMPLE: at posedge, dbg_rd_data <= (rf_we && rf_wa==addr && addr!=0) ? rf_wd : rf_rd2. Then go to DONE.
  - DONE: dbg_rd_done=1 for one cycle, then IDLE.
- Read latency with an empty FIFO: accept at edge N, done high in cycle N+2. A read of x0 returns 0.

Optional Feature:
RF_ARB_PROTECT_EN: when defined, debug writes to x2 (sp) and x3 (gp) are accepted but discarded at push. A registered output dbg_wr_err pulses 1 for one cycle. When undefined, dbg_wr_err does not exist and x2/x3 are writable like any other register.

Decomposition:
- Shared package rf_arb_pkg holds:
  - the read-FSM state enum
  - ADDR_W/DATA_W defaults
  - constants REG_ZERO=0, REG_SP=2, REG_GP=3
- One sub-module: rf_dbg_wfifo, a parameterised sync FIFO (push/pop/full/empty/head) with async active-low reset.

Test Plan:
- Reset passthrough: wb_we=1, wb_wa=5, wb_wd=0xA5A5 → rf_we=1, wa=5, wd=0xA5A5 the same cycle. With rstn=0 → rf_we=0.
- Idle-slot drain: empty core, dbg write (7, 0x1234) accepted → rf_we=1, wa=7, wd=0x1234 the next cycle; FIFO empty after.
- Full/backpressure: wb_we=1 continuously, push 2 debug writes → dbg_wr_ready=0 on the third. core_stall rises after 4 unserved cycles, drops after the first pop when wb_we falls.
- Read with bypass: dbg read x9 while the core writes x9=0xDEAD in the SAMPLE cycle → dbg_rd_data=0xDEAD, done 2 cycles after accept.
- Read after queued write: queue write (4, 0x55), immediately read x4 → FSM passes DRAIN, returns 0x55. A read of x0 returns 0.
- RF_ARB_PROTECT_EN: debug write (2, 0xFFFF) → no rf_we, dbg_wr_err pulses 1 cycle. Without the macro → x2 written.
